// File: rtl/time_set_ctrl.sv
// Front-panel set-mode controller: field select FSM, increment pulses with auto-repeat, idle timeout.
// Latency: button sampled at edge N acts at edge N+2; no backpressure, every output is registered each cycle.
module time_set_ctrl #(
    parameter int REPEAT_DLY = 3,
    parameter int TIMEOUT    = 30
) (
    input  logic       clk_1Hz,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       run_en,
    output logic [2:0] field_sel,
    output logic       blink,
    output logic       set_inc_min,
    output logic       set_inc_hour,
    output logic       set_inc_day,
    output logic       set_inc_month,
    output logic       set_inc_year
);

    localparam int HW = $clog2(REPEAT_DLY + 1);
    localparam int IW = $clog2(TIMEOUT);
    localparam logic [HW-1:0] HOLD_MAX = HW'(REPEAT_DLY);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_MIN   = 3'd1,
        ST_HOUR  = 3'd2,
        ST_DAY   = 3'd3,
        ST_MONTH = 3'd4,
        ST_YEAR  = 3'd5
    } state_e;

    logic          mode_meta_q, mode_meta_d, mode_s_q, mode_s_d, mode_dly_q, mode_dly_d;
    logic          up_meta_q, up_meta_d, up_s_q, up_s_d, up_dly_q, up_dly_d;
    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          rep_ph_q, rep_ph_d;
    logic          run_en_q, run_en_d;
    logic          blink_q, blink_d;
    logic [4:0]    inc_q, inc_d;

    logic          mode_rise, up_rise, set_active, pulse;

    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            mode_meta_q <= 1'b0;
            mode_s_q    <= 1'b0;
            mode_dly_q  <= 1'b0;
            up_meta_q   <= 1'b0;
            up_s_q      <= 1'b0;
            up_dly_q    <= 1'b0;
            state_q     <= ST_RUN;
            hold_q      <= '0;
            idle_q      <= '0;
            rep_ph_q    <= 1'b0;
            run_en_q    <= 1'b1;
            blink_q     <= 1'b0;
            inc_q       <= '0;
        end else begin
            mode_meta_q <= mode_meta_d;
            mode_s_q    <= mode_s_d;
            mode_dly_q  <= mode_dly_d;
            up_meta_q   <= up_meta_d;
            up_s_q      <= up_s_d;
            up_dly_q    <= up_dly_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            idle_q      <= idle_d;
            rep_ph_q    <= rep_ph_d;
            run_en_q    <= run_en_d;
            blink_q     <= blink_d;
            inc_q       <= inc_d;
        end
    end

    always_comb begin
        mode_meta_d = btn_mode;
        mode_s_d    = mode_meta_q;
        mode_dly_d  = mode_s_q;
        up_meta_d   = btn_up;
        up_s_d      = up_meta_q;
        up_dly_d    = up_s_q;
    end

    assign mode_rise = mode_s_q & ~mode_dly_q;
    assign up_rise   = up_s_q & ~up_dly_q;

    // Next state plus the hold/idle counters; a mode rise always wins and clears both.
    always_comb begin
        state_d    = state_q;
        hold_d     = '0;
        idle_d     = '0;
        set_active = 1'b0;
        case (state_q)
            ST_RUN:   if (mode_rise) state_d = ST_MIN;
            ST_MIN, ST_HOUR, ST_DAY, ST_MONTH, ST_YEAR: begin
                if (mode_rise) begin
                    case (state_q)
                        ST_MIN:   state_d = ST_HOUR;
                        ST_HOUR:  state_d = ST_DAY;
                        ST_DAY:   state_d = ST_MONTH;
                        ST_MONTH: state_d = ST_YEAR;
                        default:  state_d = ST_RUN;
                    endcase
                end else begin
                    set_active = 1'b1;
                    if (!mode_s_q && !up_s_q) begin
                        if (idle_q == IDLE_MAX) state_d = ST_RUN;
                        else                    idle_d  = idle_q + IW'(1);
                    end
                    if (up_s_q) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
                end
            end
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        run_en_d = (state_d == ST_RUN);
        if (state_d == ST_RUN)        blink_d = 1'b0;
        else if (state_d != state_q)  blink_d = 1'b1;
        else                          blink_d = ~blink_q;

        rep_ph_d = 1'b0;
        pulse    = 1'b0;
        if (set_active && up_s_q) begin
            // Once saturated, the phase flop gives a low-first period-2 repeat train.
            if (hold_q == HOLD_MAX) begin
                rep_ph_d = ~rep_ph_q;
                pulse    = up_rise | rep_ph_q;
            end else begin
                pulse    = up_rise;
            end
        end

        inc_d = '0;
        if (pulse) begin
            case (state_q)
                ST_MIN:   inc_d[0] = 1'b1;
                ST_HOUR:  inc_d[1] = 1'b1;
                ST_DAY:   inc_d[2] = 1'b1;
                ST_MONTH: inc_d[3] = 1'b1;
                ST_YEAR:  inc_d[4] = 1'b1;
                default:  inc_d    = '0;
            endcase
        end
    end

    assign run_en        = run_en_q;
    assign field_sel     = state_q;
    assign blink         = blink_q;
    assign set_inc_min   = inc_q[0];
    assign set_inc_hour  = inc_q[1];
    assign set_inc_day   = inc_q[2];
    assign set_inc_month = inc_q[3];
    assign set_inc_year  = inc_q[4];

endmodule
